rv_exec_divider: RTL and testbench
==================================

Name: rv_exec_divider

Overview:
Iterative radix-2 divider in the execute stage. It consumes the operand values produced by the register file read port (x_rs1_value / x_rs2_value, after writeback bypass). It executes RV32M DIV/DIVU/REM/REMU over multiple cycles. The execute-stage controller stalls decode while x_busy_o is high and captures x_result_o on x_done_o.

Parameters:
None.

Ports:
clk_i  input  1  clock, rising-edge.
rst_i  input  1  reset; asynchronous and active-high.
x_start_i  input  1  start request; operands/funct3 sampled on this edge when accepted.
x_kill_i  input  1  abort current operation (pipeline flush).
x_funct3_i  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes treated as DIVU.
x_rs1_value_i  input  32  dividend (from regfile/bypass).
x_rs2_value_i  input  32  divisor (from regfile/bypass).
x_busy_o  output  1  operation in progress.
x_done_o  output  1  one-cycle pulse; x_result_o valid this cycle.
x_result_o  output  32  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; x_busy_o=0, x_done_o=0, x_result_o=0; internal registers cleared. Reset mid-operation aborts it immediately. No done pulse follows.
- States: IDLE -> DIVIDE -> FIXUP -> IDLE.
- IDLE:
  - x_start_i=1 and x_kill_i=0 (edge N) -> latch op type, sign of operands, |rs1|, |rs2| (magnitude only for DIV/REM). Set counter=31. Enter DIVIDE.
  - x_kill_i=1 in IDLE: start ignored, stay IDLE.
- DIVIDE:
  - One restoring step per cycle over a 33-bit partial remainder.
  - Shift in the next dividend MSB. Trial-subtract the divisor; keep the result if non-negative. Shift the quotient bit in.
  - 32 cycles (N+1..N+32); counter decrements and the last step occurs at counter=0. Then go to FIXUP.
- FIXUP (cycle N+33), sign correction:
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU). Register it into x_result_o. Assert x_done_o for the next cycle. Return to IDLE.
- Timing: x_done_o=1 and x_result_o valid in cycle N+34; x_busy_o=1 in cycles N+1..N+33, 0 in cycle N+34.
- Back-to-back: a start in the done cycle (N+34) is accepted. A start while busy is ignored; there is no queuing.
- x_kill_i while busy: next cycle state=IDLE, busy=0, no done pulse; x_result_o keeps its previous value. A start presented with the kill is ignored.
- RISC-V corner results are mandatory regardless of path:
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1 unchanged. The sign fixup is suppressed when the divisor is 0.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Arithmetic is 32-bit wrap-around; magnitude of 0x80000000 is 0x80000000 as unsigned.

Optional Feature:
RV_DIV_FAST_PATH_EN.
- Defined: at accept, divisor==0 or signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) skips DIVIDE/FIXUP. The corner result is registered directly; x_done_o=1 in cycle N+1 and x_busy_o is never asserted. All other operations keep the 34-cycle latency.
- Not defined: every operation, including corners, takes the full N+34 latency with the same results.

Test Plan:
- DIVU 100/7 started at cycle 0 -> busy cycles 1-33, done cycle 34, result 14. Then REMU with the same operands -> result 2.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REM 7/0xFFFFFFFE (-2) -> 1.
- DIV 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234. With RV_DIV_FAST_PATH_EN: done at cycle 1, busy never high. Without it: done at cycle 34.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start DIVU 50/5; assert x_kill_i at cycle 10 -> busy=0 at cycle 11, no done pulse, result holds its previous value. A new start at cycle 12 (DIVU 9/3) -> done at cycle 46, result 3.
- Assert rst_i asynchronously mid-DIVIDE (cycle 20) -> busy/done/result=0 without a clock edge. After release, DIVU 1/1 -> result 1 at start+34. A start in the done cycle of a prior op is accepted (done 34 cycles later).

Source files
------------

// File: rtl/rv_exec_divider.sv
// rv_exec_divider: iterative radix-2 restoring divider for the execute stage.
// Executes the RV32M DIV/DIVU/REM/REMU operations over multiple cycles.
// Each operation runs IDLE -> DIVIDE (32 steps) -> FIXUP -> IDLE, and a
// done pulse follows 34 cycles after the start is accepted.
//
// Optional build macro: RV_DIV_FAST_PATH_EN
//   When defined, a divide by zero or a signed overflow is finished at accept
//   time: the result is ready on the next cycle and busy is never raised.
//   When undefined, every operation takes the full latency.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   x_start_i      start request; operands and funct3 are sampled on accept
//   x_kill_i       aborts the current operation, or blocks a start in IDLE
//   x_funct3_i     100=DIV 101=DIVU 110=REM 111=REMU, other codes act as DIVU
//   x_rs1_value_i  dividend
//   x_rs2_value_i  divisor
//   x_busy_o       an operation is in progress
//   x_done_o       one-cycle pulse, x_result_o is valid in this cycle
//   x_result_o     quotient or remainder, held until the next result
module rv_exec_divider (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_start_i,
  input  logic        x_kill_i,
  input  logic [2:0]  x_funct3_i,
  input  logic [31:0] x_rs1_value_i,
  input  logic [31:0] x_rs2_value_i,
  output logic        x_busy_o,
  output logic        x_done_o,
  output logic [31:0] x_result_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FIXUP
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;     // dividend shift register; holds the quotient at the end
  logic [31:0] dvs_q, dvs_d;     // divisor magnitude
  logic [31:0] rem_q, rem_d;     // partial remainder (always below the divisor)
  logic        is_rem_q, is_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Decoded view of the start request
  logic        op_signed;
  logic        op_rem;
  logic        a_neg;
  logic        b_neg;
  logic        fast_hit;
  logic [31:0] fast_res;

  // Datapath for one restoring step
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign op_signed = (x_funct3_i == 3'b100) || (x_funct3_i == 3'b110);
  assign op_rem    = (x_funct3_i == 3'b110) || (x_funct3_i == 3'b111);
  assign a_neg     = op_signed & x_rs1_value_i[31];
  assign b_neg     = op_signed & x_rs2_value_i[31];

`ifdef RV_DIV_FAST_PATH_EN
  assign fast_hit = (x_rs2_value_i == '0) ||
                    (op_signed && (x_rs1_value_i == 32'h8000_0000) && (x_rs2_value_i == '1));
  assign fast_res = (x_rs2_value_i == '0) ? (op_rem ? x_rs1_value_i : '1)
                                          : (op_rem ? '0 : 32'h8000_0000);
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // The shifted remainder is below twice the divisor, so bit 32 of the
  // 33-bit difference is set exactly when the trial subtraction goes negative.
  assign rem_shift = {rem_q, dvd_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  // With a zero divisor the loop yields all-ones and |rs1|; restoring the
  // dividend sign on the remainder returns rs1, but the quotient must stay
  // all-ones, so its negation is suppressed.
  assign quo_fix = (neg_quo_q && !div0_q) ? (32'd0 - dvd_q) : dvd_q;
  assign rem_fix = neg_rem_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (x_start_i && !x_kill_i) begin
          if (fast_hit) begin
            result_d = fast_res;
            done_d   = 1'b1;
          end else begin
            state_d   = S_DIVIDE;
            cnt_d     = 5'd31;
            dvd_d     = a_neg ? (32'd0 - x_rs1_value_i) : x_rs1_value_i;
            dvs_d     = b_neg ? (32'd0 - x_rs2_value_i) : x_rs2_value_i;
            rem_d     = '0;
            is_rem_d  = op_rem;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = (x_rs2_value_i == '0);
          end
        end
      end

      S_DIVIDE: begin
        if (x_kill_i) begin
          state_d = S_IDLE;
        end else begin
          if (!rem_diff[32]) begin
            rem_d = rem_diff[31:0];
            dvd_d = {dvd_q[30:0], 1'b1};
          end else begin
            rem_d = rem_shift[31:0];
            dvd_d = {dvd_q[30:0], 1'b0};
          end
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = S_FIXUP;
          end
        end
      end

      S_FIXUP: begin
        state_d = S_IDLE;
        if (!x_kill_i) begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign x_busy_o   = (state_q != S_IDLE);
  assign x_done_o   = done_q;
  assign x_result_o = result_q;

endmodule

// File: tb/tb_rv_exec_divider.sv
// tb_rv_exec_divider: directed, self-checking bench for rv_exec_divider.
// Expected results are pushed to a scoreboard queue when an operation is
// started and popped when the done pulse arrives. Build with
// RV_DIV_FAST_PATH_EN defined to expect the single-cycle corner path.
module tb_rv_exec_divider;

`ifdef RV_DIV_FAST_PATH_EN
  localparam bit FAST_BUILD = 1'b1;
`else
  localparam bit FAST_BUILD = 1'b0;
`endif

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  always #5 clk = ~clk;

  rv_exec_divider u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .x_start_i     (start),
    .x_kill_i      (kill),
    .x_funct3_i    (funct3),
    .x_rs1_value_i (rs1),
    .x_rs2_value_i (rs2),
    .x_busy_o      (busy),
    .x_done_o      (done),
    .x_result_o    (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; the start is accepted on the next rising edge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit corner);
    int unsigned lat_exp;
    int unsigned busy_exp;
    int unsigned k;
    int unsigned busy_cnt;
    bit          seen;
    logic [31:0] sb;
    lat_exp  = (FAST_BUILD && corner) ? 1 : 34;
    busy_exp = (FAST_BUILD && corner) ? 0 : 33;
    exp_q.push_back(exp);
    start  = 1'b1;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    @(posedge clk);
    #1 start = 1'b0;
    k        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, k, lat_exp);
      check({tag, " busy_cycles"}, busy_cnt, busy_exp);
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({tag, " result"}, result, sb);
      last_result = sb;
    end
  endtask

  initial begin
    int unsigned bad;
    rst    = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic ops, each start lands in the done cycle of the previous op
    run_op("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu 100/7", F_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem -7/2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("rem 7/-2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op("div -100/-7", F_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
    run_op("funct3 000 as divu", 3'b000, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 1'b0);
    run_op("divu big/max", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("remu big/max", F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

    // Corner results
    run_op("div x/0", F_DIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("rem x/0", F_REM, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1);
    run_op("div -5/0", F_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("rem -5/0", F_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
    run_op("divu x/0", F_DIVU, 32'h0000_0055, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Kill mid-divide: start at cycle 0, kill sampled at the end of cycle 10
    repeat (2) @(negedge clk);
    start  = 1'b1;
    funct3 = F_DIVU;
    rs1    = 32'd50;
    rs2    = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy || done) bad++;
    end
    check("kill busy before", bad, 0);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy after", 32'(busy), 32'd0);
    check("kill no done", 32'(done), 32'd0);
    check("kill result held", result, last_result);
    @(negedge clk);
    run_op("divu 9/3 after kill", F_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Start presented together with kill in IDLE is ignored
    @(negedge clk);
    start  = 1'b1;
    kill   = 1'b1;
    funct3 = F_DIVU;
    rs1    = 32'd8;
    rs2    = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    bad   = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    check("kill blocks idle start", bad, 0);

    // Asynchronous reset mid-divide
    start  = 1'b1;
    funct3 = F_DIVU;
    rs1    = 32'd1000;
    rs2    = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_result = '0;
    @(negedge clk);
    run_op("divu 1/1", F_DIVU, 32'd1, 32'd1, 32'd1, 1'b0);
    run_op("divu back-to-back", F_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0);

    @(negedge clk);
    check("done pulse width", 32'(done), 32'd0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
